// File: rtl/fp_fused_muladd_pipe.sv
// fp_fused_muladd_pipe: 3-stage fused +/-(A*B) +/- C with valid/ready handshake and nv/of/uf flags.
// Build option FP_MULADD_RNE_EN selects round-to-nearest-even; without it results are truncated.
module fp_fused_muladd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [EXP_W+MAN_W:0]   c,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int MW  = MAN_W + 1;
    localparam int PW  = 2 * MW;
    localparam int SW  = PW + 4;            // carry + product + guard/round/sticky
    localparam int XW  = EXP_W + 2;
    localparam int LZW = $clog2(SW + 1);
    localparam logic [XW-1:0]    BIAS     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic [XW-1:0]    EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
`ifdef FP_MULADD_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    typedef struct packed {
        logic          valid;
        logic          nan;
        logic          inf;
        logic          inf_sign;
        logic          psign;
        logic          csign;
        logic [PW-1:0] pman;
        logic [MW-1:0] cman;
        logic [XW-1:0] pexp;
        logic [XW-1:0] cexp;
    } s1_t;

    typedef struct packed {
        logic          valid;
        logic          nan;
        logic          inf;
        logic          inf_sign;
        logic          sign;
        logic [SW-1:0] sum;
        logic [XW-1:0] exp;
    } s2_t;

    function automatic logic [SW-1:0] shr_sticky(input logic [SW-1:0] x, input logic [XW-1:0] sh);
        logic [SW-1:0] mask;
        if (sh >= XW'(SW)) return {{(SW-1){1'b0}}, |x};
        mask = ~({SW{1'b1}} << sh);
        return (x >> sh) | {{(SW-1){1'b0}}, |(x & mask)};
    endfunction

    function automatic logic [LZW-1:0] lzc(input logic [SW-1:0] x);
        logic [LZW-1:0] n;
        n = LZW'(SW);
        for (int i = 0; i < SW; i++) begin
            if (x[i]) n = LZW'(SW - 1 - i);
        end
        return n;
    endfunction

    s1_t s1_new, s1_d, s1_q;
    s2_t s2_new, s2_d, s2_q;
    logic           out_v_d, out_v_q;
    logic [W-1:0]   res_new, res_d, res_q;
    logic [2:0]     flags_new, flags_d, flags_q;
    logic           advance;

    assign advance   = en & (~out_v_q | out_ready);
    assign in_ready  = advance;
    assign out_valid = en & out_v_q;
    assign result    = en ? res_q : '0;
    assign flags     = en ? flags_q : 3'b000;

    // Stage 1: unpack (subnormals flush to zero), sign mode, product and exponent sum
    logic [EXP_W-1:0] ea, eb, ec;
    logic a_zero, b_zero, c_zero, a_inf, b_inf, c_inf, a_nan, b_nan, c_nan;
    logic psign, csign, prod_zero, prod_inf;
    logic [XW-1:0] pexp_raw, cexp_raw;
    always_comb begin
        ea = a[W-2 -: EXP_W];
        eb = b[W-2 -: EXP_W];
        ec = c[W-2 -: EXP_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        c_zero = (ec == '0);
        a_inf  = (ea == EXP_ONES) && (a[MAN_W-1:0] == '0);
        b_inf  = (eb == EXP_ONES) && (b[MAN_W-1:0] == '0);
        c_inf  = (ec == EXP_ONES) && (c[MAN_W-1:0] == '0);
        a_nan  = (ea == EXP_ONES) && (a[MAN_W-1:0] != '0);
        b_nan  = (eb == EXP_ONES) && (b[MAN_W-1:0] != '0);
        c_nan  = (ec == EXP_ONES) && (c[MAN_W-1:0] != '0);
        psign = a[W-1] ^ b[W-1] ^ op[1];
        csign = c[W-1] ^ op[0];
        prod_zero = a_zero | b_zero;
        prod_inf  = (a_inf | b_inf) & ~prod_zero;
        pexp_raw = XW'(ea) + XW'(eb) - BIAS;
        cexp_raw = XW'(ec);

        s1_new          = '0;
        s1_new.valid    = in_valid;
        s1_new.nan      = a_nan | b_nan | c_nan | ((a_inf | b_inf) & prod_zero)
                        | (prod_inf & c_inf & (psign != csign));
        s1_new.inf      = prod_inf | c_inf;
        s1_new.inf_sign = prod_inf ? psign : csign;
        s1_new.psign    = psign;
        s1_new.csign    = csign;
        s1_new.pman     = prod_zero ? '0 : PW'({1'b1, a[MAN_W-1:0]}) * PW'({1'b1, b[MAN_W-1:0]});
        s1_new.cman     = c_zero ? '0 : {1'b1, c[MAN_W-1:0]};
        // A zero term borrows the other term's exponent so it never forces an alignment shift
        s1_new.pexp     = prod_zero ? cexp_raw : pexp_raw;
        s1_new.cexp     = c_zero ? pexp_raw : cexp_raw;
        s1_d = advance ? s1_new : s1_q;
    end

    // Stage 2: align the smaller-exponent term with sticky, then signed-magnitude add
    logic [XW-1:0] diff, sh;
    logic [SW-1:0] p_ext, c_ext, p_al, c_al;
    always_comb begin
        p_ext = {1'b0, s1_q.pman, 3'b000};
        c_ext = {1'b0, s1_q.cman, {MAN_W{1'b0}}, 3'b000};
        diff  = s1_q.pexp - s1_q.cexp;
        s2_new          = '0;
        s2_new.valid    = s1_q.valid;
        s2_new.nan      = s1_q.nan;
        s2_new.inf      = s1_q.inf;
        s2_new.inf_sign = s1_q.inf_sign;
        if (!diff[XW-1]) begin
            sh   = diff;
            p_al = p_ext;
            c_al = shr_sticky(c_ext, sh);
            s2_new.exp = s1_q.pexp;
        end else begin
            sh   = -diff;
            p_al = shr_sticky(p_ext, sh);
            c_al = c_ext;
            s2_new.exp = s1_q.cexp;
        end
        if (s1_q.psign == s1_q.csign) begin
            s2_new.sum  = p_al + c_al;
            s2_new.sign = s1_q.psign;
        end else if (p_al >= c_al) begin
            s2_new.sum  = p_al - c_al;
            s2_new.sign = s1_q.psign;
        end else begin
            s2_new.sum  = c_al - p_al;
            s2_new.sign = s1_q.csign;
        end
        // Exact zero is negative only when both signed terms are negative zeros
        if (s2_new.sum == '0) s2_new.sign = s1_q.psign & s1_q.csign;
        s2_d = advance ? s2_new : s2_q;
    end

    // Stage 3: normalise, round, range check, pack
    logic [LZW-1:0]   lz;
    logic [SW-1:0]    norm;
    logic [MW-1:0]    mant;
    logic             guard, sticky, inc;
    logic [MW:0]      mant_r;
    logic [MAN_W-1:0] frac;
    logic [XW-1:0]    exp_n, exp_r;
    always_comb begin
        lz     = lzc(s2_q.sum);
        norm   = s2_q.sum << lz;
        mant   = norm[SW-1 -: MW];
        guard  = norm[SW-1-MW];
        sticky = |norm[SW-2-MW:0];
        inc    = RNE & guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + (MW+1)'(inc);
        frac   = mant_r[MW] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_n  = s2_q.exp + XW'(2) - XW'(lz);
        exp_r  = exp_n + XW'(mant_r[MW]);

        res_new   = '0;
        flags_new = 3'b000;
        if (s2_q.nan) begin
            res_new   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
            flags_new = 3'b100;
        end else if (s2_q.inf) begin
            res_new = {s2_q.inf_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s2_q.sum == '0) begin
            res_new = {s2_q.sign, {(W-1){1'b0}}};
        end else if (!exp_r[XW-1] && exp_r >= EXP_MAX) begin
            res_new   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_new = 3'b010;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            res_new   = {s2_q.sign, {(W-1){1'b0}}};
            flags_new = 3'b001;
        end else begin
            res_new = {s2_q.sign, exp_r[EXP_W-1:0], frac};
        end

        out_v_d = advance ? s2_q.valid : out_v_q;
        res_d   = advance ? (s2_q.valid ? res_new : '0) : res_q;
        flags_d = advance ? (s2_q.valid ? flags_new : 3'b000) : flags_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            out_v_q <= 1'b0;
            res_q   <= '0;
            flags_q <= 3'b000;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            out_v_q <= out_v_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end
endmodule
